// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one 8-bit ALU among NREQ requesters.
// Optional zero/carry response flags are enabled by defining ALU_SCHED_FLAGS_EN.

package alu_sched_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } opcode_e;
endpackage

module alu
  import alu_sched_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  opcode_e    i_op,
`ifdef ALU_SCHED_FLAGS_EN
  output logic       o_carry,
`endif
  output logic [7:0] o_y
);

  always_comb begin
    o_y = 8'h00;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      default: o_y = 8'h00;
    endcase
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic [8:0] w_add9;
  logic [8:0] w_sub9;

  // Bit 8 of the widened difference is the unsigned borrow (a < b).
  assign w_add9 = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub9 = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_carry = 1'b0;
    case (i_op)
      OP_ADD:  o_carry = w_add9[8];
      OP_SUB:  o_carry = w_sub9[8];
      default: o_carry = 1'b0;
    endcase
  end
`endif

endmodule

module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
`ifdef ALU_SCHED_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_carry,
`endif
  output logic [7:0]        rsp_y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  opcode_e         r_op;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [7:0]      r_rsp_y;
  logic [IDW-1:0]  w_grant;
  logic            w_any;
  logic            w_accept;
  logic [NREQ-1:0] w_req_ready;
  logic [7:0]      w_alu_y;

  // Smallest offset from last+1 wins; the loop runs downward so the final hit is the nearest.
  function automatic logic [IDW-1:0] f_pick(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  last);
    int k;
    f_pick = last;
    for (int i = NREQ; i >= 1; i--) begin
      k = (int'(last) + i) % NREQ;
      if (v[k]) f_pick = k[IDW-1:0];
    end
  endfunction

  assign w_grant  = f_pick(req_valid, r_last);
  assign w_any    = |req_valid;
  assign w_accept = (r_state == S_IDLE) && w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gated by rst_n so no grant is advertised while the block is held in reset.
  always_comb begin
    w_req_ready = '0;
    if (rst_n && w_accept)
      w_req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_grant;
  end

  assign req_ready = w_req_ready;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= req_a[8*w_grant +: 8];
      r_b  <= req_b[8*w_grant +: 8];
      r_op <= opcode_e'(req_op[2*w_grant +: 2]);
      r_id <= w_grant;
    end
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic w_alu_carry;
  logic r_rsp_zero;
  logic r_rsp_carry;

  alu u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_carry (w_alu_carry),
    .o_y     (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_zero  <= (w_alu_y == 8'h00);
      r_rsp_carry <= w_alu_carry;
    end
  end

  assign rsp_zero  = r_rsp_zero;
  assign rsp_carry = r_rsp_carry;
`else
  alu u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 8'h00;
      r_last      <= IDW'(NREQ - 1);
    end else begin
      if (r_state == S_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_y     <= w_alu_y;
      end else if (r_state == S_RESP && r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_last      <= r_rsp_id;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed testbench for alu_rr_sched (4 requesters); flag checks compile in with ALU_SCHED_FLAGS_EN.

module tb_alu_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
`ifdef ALU_SCHED_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_carry;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_rr_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ALU_SCHED_FLAGS_EN
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
`endif
    .rsp_y     (rsp_y)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
    req_valid[i]      = 1'b1;
    req_a[8*i +: 8]   = a;
    req_b[8*i +: 8]   = b;
    req_op[2*i +: 2]  = op;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", rsp_y); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_y !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_quiet c%0d: ready=%b valid=%b y=%h want 0000/0/00", c, req_ready, rsp_valid, rsp_y);
      end
    end
  endtask

  task automatic test_single_add;
    drive_req(2, 8'hF0, 8'h20, 2'd0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL add_grant: got %b want 0100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL add_exec: valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 8'h10) begin
      n_fail++; $display("FAIL add_rsp: valid=%b id=%0d y=%h want 1/2/10", rsp_valid, rsp_id, rsp_y);
    end
`ifdef ALU_SCHED_FLAGS_EN
    n_checks++;
    if (rsp_carry !== 1'b1 || rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL add_flags: carry=%b zero=%b want 1/0", rsp_carry, rsp_zero);
    end
`endif
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_consumed: valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) drive_req(i, 8'(i), 8'(i), 2'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << k)) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'b0001 << k);
      end
      step();
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_exec_ready%0d: got %b want 0000", k, req_ready); end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k) || rsp_y !== 8'h00) begin
        n_fail++; $display("FAIL rr_rsp%0d: valid=%b id=%0d y=%h want 1/%0d/00", k, rsp_valid, rsp_id, rsp_y, k);
      end
`ifdef ALU_SCHED_FLAGS_EN
      n_checks++;
      if (rsp_zero !== 1'b1 || rsp_carry !== 1'b0) begin
        n_fail++; $display("FAIL rr_flags%0d: zero=%b carry=%b want 1/0", k, rsp_zero, rsp_carry);
      end
`endif
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    drive_req(1, 8'h0F, 8'hA0, 2'd3);
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    step();
    req_valid[1] = 1'b0;
    drive_req(0, 8'h01, 8'h02, 2'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'hAF || rsp_id !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b y=%h id=%0d want 1/af/1", c, rsp_valid, rsp_y, rsp_id);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_noready%0d: got %b want 0000", c, req_ready); end
      if (c < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_grant: ready=%b valid=%b want 0001/0", req_ready, rsp_valid);
    end
    step();
    req_valid[0] = 1'b0;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 8'h03) begin
      n_fail++; $display("FAIL bp_second: valid=%b id=%0d y=%h want 1/0/03", rsp_valid, rsp_id, rsp_y);
    end
    step();
  endtask

  task automatic test_reset_midflight;
    drive_req(3, 8'h3C, 8'h0F, 2'd2);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %b want 1000", req_ready); end
    step();
    req_valid[3] = 1'b0;
    drive_req(0, 8'h05, 8'h06, 2'd0);
    drive_req(2, 8'h11, 8'h22, 2'd0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset_out: ready=%b valid=%b y=%h id=%0d want 0000/0/00/0", req_ready, rsp_valid, rsp_y, rsp_id);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: valid=%b want 0", rsp_valid); end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 8'h0B) begin
      n_fail++; $display("FAIL mid_rsp0: valid=%b id=%0d y=%h want 1/0/0b", rsp_valid, rsp_id, rsp_y);
    end
    step();
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant2: got %b want 0100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 8'h33) begin
      n_fail++; $display("FAIL mid_rsp2: valid=%b id=%0d y=%h want 1/2/33", rsp_valid, rsp_id, rsp_y);
    end
    step();
  endtask

  task automatic test_alu_ops;
    int         t_id[6] = '{0, 3, 1, 2, 0, 1};
    logic [7:0] t_a[6]  = '{8'h05, 8'h3C, 8'h80, 8'h00, 8'hFF, 8'h07};
    logic [7:0] t_b[6]  = '{8'h07, 8'h0F, 8'h80, 8'h00, 8'h01, 8'h05};
    logic [1:0] t_op[6] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
    logic [7:0] t_y[6]  = '{8'hFE, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h02};
    logic       t_z[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       t_c[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      drive_req(t_id[k], t_a[k], t_b[k], t_op[k]);
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << t_id[k])) begin
        n_fail++; $display("FAIL op%0d_grant: got %b want %b", k, req_ready, 4'b0001 << t_id[k]);
      end
      step();
      req_valid = 4'b0000;
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(t_id[k]) || rsp_y !== t_y[k]) begin
        n_fail++; $display("FAIL op%0d_rsp: valid=%b id=%0d y=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_y, t_id[k], t_y[k]);
      end
`ifdef ALU_SCHED_FLAGS_EN
      n_checks++;
      if (rsp_zero !== t_z[k] || rsp_carry !== t_c[k]) begin
        n_fail++; $display("FAIL op%0d_flags: zero=%b carry=%b want %b/%b", k, rsp_zero, rsp_carry, t_z[k], t_c[k]);
      end
`else
      if (t_z[k] !== (t_y[k] == 8'h00) && t_c[k] === 1'bx) n_fail++;
`endif
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_alu_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one 8-bit ALU (ADD/SUB/AND/OR, `opcode_e` encoding 0..3) among `NREQ` requesters.
- Accepts one operation at a time over a valid/ready handshake.
- Registers the operands, executes them on an internally instantiated `alu`, and returns the result tagged with the requester index.
- Sits between the requester agents and the shared ALU datapath.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NREQ`: per-requester request valid.
- `req_ready`, out, `NREQ`: per-requester accept; one-hot or zero.
- `req_a`, in, `NREQ*8`: operand A; requester i uses slice [8i+7:8i].
- `req_b`, in, `NREQ*8`: operand B; same slicing as `req_a`.
- `req_op`, in, `NREQ*2`: opcode; requester i uses slice [2i+1:2i], cast to `opcode_e`.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: downstream accepts the response.
- `rsp_id`, out, `IDW`: index of the requester that is being answered.
- `rsp_y`, out, 8: ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, grant the first valid index found searching upward from `last+1`, wrapping from `NREQ-1` to 0.
  - Assert `req_ready[grant]` combinationally in the same cycle.
  - Capture the granted a/b/op and the grant index into internal registers, then go to EXEC.
  - If no `req_valid` is high, stay in IDLE with `req_ready=0`.
- EXEC:
  - The ALU is driven from the captured registers.
  - Register the result into `rsp_y`, load `rsp_id`, set `rsp_valid=1`, and go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_id` and `rsp_y` stable until `rsp_ready` is high.
  - On a cycle with `rsp_valid && rsp_ready`: clear `rsp_valid`, set `last` = the served index, and go to IDLE.
- `req_ready` is 0 in EXEC and RESP. No new request is accepted until the current response has been consumed.
- Requester rule: once `req_valid` is raised, valid and payload stay stable until `req_ready` is seen for that requester. Withdrawing `req_valid` before the grant is a protocol violation; behaviour in that case is not checked.
- Arithmetic is modulo 256:
  - ADD wraps.
  - SUB is two's-complement (a−b mod 256).
  - AND and OR are bitwise.
- Reset values:
  - All `req_ready` bits 0.
  - `rsp_valid` 0, `rsp_id` 0, `rsp_y` 0.
  - `last` = `NREQ-1`, so requester 0 has first priority after reset.
- Asserting `rst_n` low in any state:
  - Immediately returns the FSM to IDLE and clears all outputs.
  - Any in-flight transaction is dropped, with no response.
  - The dropped requester was already handshaken and must reissue.

## Timing
- Accept (`req_valid && req_ready`) in cycle N → `rsp_valid` high from cycle N+2.
- With `rsp_ready` held at 1, response handshake completes in N+2, and the next accept can happen at N+3.
- Maximum throughput: one operation per 3 cycles.
- `rsp_ready` backpressure extends RESP indefinitely; outputs hold stable throughout.
- `rsp_ready` high while `rsp_valid` is 0 has no effect.
- Fairness: with all `NREQ` requesters continuously valid, each is served exactly once per `NREQ` operations.

## Configuration
- Macro: `ALU_SCHED_FLAGS_EN`.
- Defined: adds outputs `rsp_zero` (1 bit) and `rsp_carry` (1 bit), registered alongside `rsp_y` with identical timing; both reset to 0.
  - `rsp_zero` = (`rsp_y` == 0).
  - `rsp_carry` for ADD = bit 8 of the 9-bit sum.
  - `rsp_carry` for SUB = borrow (a < b, unsigned).
  - `rsp_carry` for AND and OR = 0.
- Undefined: the ports do not exist, and no flag logic is synthesised.

## Test plan
- Reset, then no requests for 10 cycles → `req_ready`=0, `rsp_valid`=0, `rsp_y`=0 throughout.
- Requester 2 only: a=0xF0, b=0x20, ADD; `rsp_ready`=1 → `rsp_valid` exactly 2 cycles after accept, `rsp_id`=2, `rsp_y`=0x10. With flags enabled: `rsp_carry`=1, `rsp_zero`=0.
- All 4 requesters valid with SUB, a=i, b=i, held for 4 operations → grant order 0,1,2,3, each `rsp_y`=0x00. With flags enabled: `rsp_zero`=1, `rsp_carry`=0.
- Requester 1 issues OR, 0x0F|0xA0; `rsp_ready` held low for 5 cycles → `rsp_valid`/`rsp_y`=0xAF/`rsp_id`=1 stable all 5 cycles; `req_ready[0]` stays 0 despite requester 0 being valid. Requester 0 is then accepted the cycle after the response handshake.
- Requester 3 issues AND, 0x3C&0x0F; `rst_n` pulsed low in EXEC → outputs 0 immediately. After release, requester 0 (valid) is granted first; no response is ever produced for requester 3's dropped operation.
- SUB with a=0x05, b=0x07 → `rsp_y`=0xFE. With flags enabled: `rsp_carry`=1.
